mix_columns_seq: RTL and testbench

Iterative AES MixColumns stage that sits directly downstream of ShiftRows in the AES core round datapath. It consumes the 128-bit ShiftRows output, applies the FIPS-197 MixColumns transform one or more columns per clock, and presents the result to the AddRoundKey/round register under a valid/ready handshake. A last-round bypass passes the state through unchanged with the same latency, so round timing stays uniform.

---
 rtl/mix_columns_seq.sv | 164 ++++++++++++++++
 tb/tb_mix_columns_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns stage with a last-round bypass.
// A 128-bit state is accepted in IDLE. BUSY transforms P columns per
// cycle into the output register, and DONE presents the result under
// a valid/ready handshake. Bypass follows the same FSM and cycle count,
// so round timing is identical whether or not MixColumns is applied.
module mix_columns_seq #(
    parameter int P_COLS_PER_CYCLE = 1
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iValid,
    output logic         oReady,
    input  logic [127:0] iText,
    input  logic         iLastRound,
    output logic         oValid,
    input  logic         iReady,
    output logic [127:0] oMixColumnsOut
);

    // The column counter advances by P each BUSY cycle. For P=4 the step
    // truncates to 0, which is harmless: the only group is the last one.
    localparam logic [1:0] CNT_STEP = 2'(P_COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(4 - P_COLS_PER_CYCLE);
    // Low counter bits that select a column inside the current group.
    localparam logic [1:0] GRP_MASK = 2'(P_COLS_PER_CYCLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [1:0]    cnt_r;
    logic [1:0]    cnt_nxt_s;
    logic          load_s;
    logic [127:0]  work_r;
    logic          bypass_r;
    logic [127:0]  out_r;
    logic [127:0]  out_nxt_s;
    logic          valid_r;

    // GF(2^8) multiply by 2 with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by 3.
    function automatic logic [7:0] mul3(input logic [7:0] b);
        mul3 = xtime(b) ^ b;
    endfunction

    // MixColumns on one 32-bit column, row 0 in the most significant byte.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] r3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        r0 = xtime(a0) ^ mul3(a1) ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ mul3(a2) ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ mul3(a3);
        r3 = mul3(a0) ^ a1 ^ a2 ^ xtime(a3);
        mix_col = {r0, r1, r2, r3};
    endfunction

    // Accept only from IDLE and never while reset is asserted.
    assign oReady         = (state_r == ST_IDLE) && !iRst;
    assign oValid         = valid_r;
    assign oMixColumnsOut = out_r;

    // Next-state and column-counter decode for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        load_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (iValid) begin
                    state_nxt_s = ST_BUSY;
                    cnt_nxt_s   = 2'd0;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_nxt_s = cnt_r + CNT_STEP;
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (iReady) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 2'd0;
            end
        endcase
    end

    // Output-register update: in BUSY, write the column group selected by cnt.
    always_comb begin
        out_nxt_s = out_r;
        for (int j = 0; j < 4; j++) begin
            if ((state_r == ST_BUSY) && ((2'(j) & ~GRP_MASK) == cnt_r)) begin
                if (bypass_r) begin
                    out_nxt_s[127-32*j -: 32] = work_r[127-32*j -: 32];
                end else begin
                    out_nxt_s[127-32*j -: 32] = mix_col(work_r[127-32*j -: 32]);
                end
            end else begin
                out_nxt_s[127-32*j -: 32] = out_r[127-32*j -: 32];
            end
        end
    end

    // Control registers: FSM state, column counter and registered valid flag.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Datapath registers: captured input state, bypass flag and result.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            work_r   <= 128'h0;
            bypass_r <= 1'b0;
            out_r    <= 128'h0;
        end else begin
            if (load_s) begin
                work_r   <= iText;
                bypass_r <= iLastRound;
            end else begin
                work_r   <= work_r;
                bypass_r <= bypass_r;
            end
            out_r <= out_nxt_s;
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: three instances (P=1,2,4)
// share the input side; each one's outputs are checked separately.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         iRst;
    logic         iValid;
    logic [127:0] iText;
    logic         iLastRound;
    logic         iReady;
    logic [2:0]   rdy;
    logic [2:0]   vld;
    logic [127:0] out_a [3];

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] COL_A_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] COL_A_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] COL_B_IN  = 128'hd4d4d4d5_c6c6c6c6_db135345_2d26314c;
    localparam logic [127:0] COL_B_OUT = 128'hd5d5d7d6_c6c6c6c6_8e4da1bc_4d7ebdf8;

    typedef struct {
        logic [127:0] text;
        logic         last;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [7];
    int   exp_lat [3];

    always #5 clk = ~clk;

    mix_columns_seq #(.P_COLS_PER_CYCLE(1)) u_p1 (
        .iClk(clk), .iRst(iRst), .iValid(iValid), .oReady(rdy[0]),
        .iText(iText), .iLastRound(iLastRound), .oValid(vld[0]),
        .iReady(iReady), .oMixColumnsOut(out_a[0])
    );
    mix_columns_seq #(.P_COLS_PER_CYCLE(2)) u_p2 (
        .iClk(clk), .iRst(iRst), .iValid(iValid), .oReady(rdy[1]),
        .iText(iText), .iLastRound(iLastRound), .oValid(vld[1]),
        .iReady(iReady), .oMixColumnsOut(out_a[1])
    );
    mix_columns_seq #(.P_COLS_PER_CYCLE(4)) u_p4 (
        .iClk(clk), .iRst(iRst), .iValid(iValid), .oReady(rdy[2]),
        .iText(iText), .iLastRound(iLastRound), .oValid(vld[2]),
        .iReady(iReady), .oMixColumnsOut(out_a[2])
    );

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Wait (bounded) until all three instances are ready, at a negedge.
    task automatic wait_all_ready(input string name);
        int waited;
        waited = 0;
        @(negedge clk);
        while (rdy != 3'b111 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check_int({name, "_ready"}, int'(rdy), 7);
    endtask

    // One block through all instances: check data and latency, then consume.
    task automatic do_block(input string name, input vec_t v);
        int           lat [3];
        logic [127:0] cap [3];
        lat = '{0, 0, 0};
        cap = '{128'h0, 128'h0, 128'h0};
        wait_all_ready(name);
        iText      = v.text;
        iLastRound = v.last;
        iValid     = 1'b1;
        @(posedge clk);
        #1;
        iValid     = 1'b0;
        iText      = ~v.text;
        iLastRound = ~v.last;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (vld[d] && lat[d] == 0) begin
                    lat[d] = k;
                    cap[d] = out_a[d];
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            check128($sformatf("%s_data_p%0d", name, d), cap[d], v.exp);
            check_int($sformatf("%s_lat_p%0d", name, d), lat[d], exp_lat[d]);
        end
        iReady = 1'b1;
        @(posedge clk);
        #1;
        iReady = 1'b0;
        @(negedge clk);
        check_int({name, "_consumed"}, int'(vld), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_acc;
        int n_out;
        int acc_cyc [2];
        int waited;
        logic [127:0] b2b_exp [2];

        exp_lat = '{5, 3, 2};
        vecs[0] = '{FIPS_IN,  1'b0, FIPS_OUT};
        vecs[1] = '{COL_A_IN, 1'b0, COL_A_OUT};
        vecs[2] = '{COL_B_IN, 1'b0, COL_B_OUT};
        vecs[3] = '{128'h00112233_44556677_8899aabb_ccddeeff, 1'b1,
                    128'h00112233_44556677_8899aabb_ccddeeff};
        vecs[4] = '{128'h0, 1'b0, 128'h0};
        vecs[5] = '{128'hffffffff_ffffffff_ffffffff_ffffffff, 1'b0,
                    128'hffffffff_ffffffff_ffffffff_ffffffff};
        vecs[6] = '{FIPS_IN,  1'b1, FIPS_IN};

        // Reset state
        iRst = 1'b1; iValid = 1'b0; iText = 128'h0; iLastRound = 1'b0; iReady = 1'b0;
        repeat (3) @(negedge clk);
        check_int("rst_ready", int'(rdy), 0);
        check_int("rst_valid", int'(vld), 0);
        for (int d = 0; d < 3; d++) check128($sformatf("rst_out_p%0d", d), out_a[d], 128'h0);
        @(posedge clk);
        #1;
        iRst = 1'b0;
        @(negedge clk);
        check_int("ready_after_rst", int'(rdy), 7);

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            do_block($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset mid-BUSY: P=1 at cnt=2, P=2 and P=4 already in DONE
        wait_all_ready("midrst");
        iText = FIPS_IN; iLastRound = 1'b0; iValid = 1'b1;
        @(posedge clk);
        #1;
        iValid = 1'b0;
        repeat (3) @(negedge clk);
        check_int("midrst_p2_done", int'(vld[1]), 1);
        iRst = 1'b1;
        #1;
        check_int("midrst_ready_in_rst", int'(rdy), 0);
        @(posedge clk);
        #1;
        iRst = 1'b0;
        @(negedge clk);
        check_int("midrst_valid", int'(vld), 0);
        for (int d = 0; d < 3; d++) check128($sformatf("midrst_out_p%0d", d), out_a[d], 128'h0);
        check_int("midrst_ready", int'(rdy), 7);
        repeat (6) @(negedge clk);
        check_int("midrst_no_result", int'(vld), 0);
        do_block("after_rst", vecs[0]);

        // Backpressure on P=1 with iValid/iText toggling
        wait_all_ready("bp");
        iText = FIPS_IN; iLastRound = 1'b0; iValid = 1'b1;
        @(posedge clk);
        #1;
        iValid = 1'b0;
        waited = 0;
        while (!vld[0] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_int("bp_valid_rise", int'(vld[0]), 1);
        for (int k = 0; k < 10; k++) begin
            iValid = k[0];
            iText  = {4{32'(k) ^ 32'h5a5a5a5a}};
            iLastRound = k[1];
            @(negedge clk);
            check_int($sformatf("bp_valid_c%0d", k), int'(vld[0]), 1);
            check128($sformatf("bp_out_c%0d", k), out_a[0], FIPS_OUT);
            check_int($sformatf("bp_ready_c%0d", k), int'(rdy[0]), 0);
        end
        // Output handshake with a simultaneous input offer
        iText = COL_A_IN; iLastRound = 1'b0; iValid = 1'b1; iReady = 1'b1;
        @(posedge clk);
        #1;
        iReady = 1'b0;
        @(negedge clk);
        check_int("bp_consumed", int'(vld[0]), 0);
        check_int("bp_idle_ready", int'(rdy[0]), 1);
        check128("bp_out_kept", out_a[0], FIPS_OUT);
        @(posedge clk);
        #1;
        iValid = 1'b0;
        waited = 0;
        while (vld != 3'b111 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_int("bp_next_latency", waited, 5);
        check128("bp_next_out", out_a[0], COL_A_OUT);
        iReady = 1'b1;
        @(posedge clk);
        #1;
        iReady = 1'b0;

        // Back-to-back with iValid and iReady held high (P=1 observed)
        wait_all_ready("b2b");
        b2b_exp = '{COL_A_OUT, COL_B_OUT};
        acc_cyc = '{0, 0};
        n_acc = 0;
        n_out = 0;
        iReady = 1'b1; iText = COL_A_IN; iLastRound = 1'b0; iValid = 1'b1;
        for (int k = 0; k < 40 && n_out < 2; k++) begin
            if (k > 0) @(negedge clk);
            if (iValid && rdy[0] && n_acc < 2) begin
                acc_cyc[n_acc] = k;
                n_acc++;
            end
            if (vld[0]) begin
                check128($sformatf("b2b_out%0d", n_out), out_a[0], b2b_exp[n_out]);
                n_out++;
            end
            @(posedge clk);
            #1;
            if (n_acc == 1) iText = COL_B_IN;
            if (n_acc >= 2) iValid = 1'b0;
        end
        check_int("b2b_outputs", n_out, 2);
        check_int("b2b_spacing", acc_cyc[1] - acc_cyc[0], 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
